// File: rtl/bpu_gshare_pkg.sv
// bpu_gshare_pkg: shared definitions for the branch prediction unit.
// Holds the 2-bit counter encodings, the predictor FSM state type and the
// clog2 helper used to size the PHT index.
package bpu_gshare_pkg;
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic {BPU_INIT, BPU_RUN} bpu_state_t;

    function automatic int clog2(input int n);
        int r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction
endpackage

// File: rtl/bpu_gshare_if.sv
// bpu_gshare_if: pipeline-side signal bundle of the branch predictor.
// master: pipeline (drives stall/flush, fetch PC, D/M branch info)
// slave : predictor (returns D prediction, its index, M mispredict, init_done)
interface bpu_gshare_if #(parameter int IDX_W = 10);
    logic             stallD;
    logic             flushD;
    logic [31:0]      pcF;
    logic             branchD;
    logic [31:0]      pcM;
    logic             branchM;
    logic             actual_takeM;
    logic             pred_takeM;
    logic [IDX_W-1:0] pht_idxM;
    logic             pred_takeD;
    logic [IDX_W-1:0] pht_idxD;
    logic             mispredM;
    logic             init_done;

    modport master (
        output stallD, flushD, pcF, branchD, pcM, branchM, actual_takeM, pred_takeM, pht_idxM,
        input  pred_takeD, pht_idxD, mispredM, init_done
    );
    modport slave (
        input  stallD, flushD, pcF, branchD, pcM, branchM, actual_takeM, pred_takeM, pht_idxM,
        output pred_takeD, pht_idxD, mispredM, init_done
    );
endinterface

// File: rtl/bpu_gshare_pht_ram.sv
// pht_ram: DEPTH x 2-bit pattern history table in distributed RAM.
// Ports: clk; raddr/rdata asynchronous lookup port; we/waddr write port which
// either stores WNT (init=1, sweep) or applies a saturating counter step in
// direction taken to the entry at waddr (init=0, M-stage training).
module pht_ram
    import bpu_gshare_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic             init,
    input  logic             taken,
    input  logic [IDX_W-1:0] waddr,
    input  logic [IDX_W-1:0] raddr,
    output logic [1:0]       rdata
);
    logic [1:0] mem [DEPTH];
    logic [1:0] cur, wdata;

    // Read-modify-write of the training entry happens within one cycle, so
    // the lookup port sees the old value on a same-index collision.
    assign cur   = mem[waddr];
    assign wdata = init  ? WNT :
                   taken ? (cur == ST  ? ST  : cur + 2'd1) :
                           (cur == SNT ? SNT : cur - 2'd1);
    assign rdata = mem[raddr];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
endmodule

// File: rtl/bpu_gshare.sv
// bpu_gshare: bimodal / gshare branch predictor with speculative GHR repair.
// Ports: clk, rst (sync, active high); bus (bpu_gshare_if.slave) carrying the
// F-stage PC, D-stage stall/flush/branch, M-stage resolution and returning
// pred_takeD, pht_idxD, mispredM and init_done.
// After reset the PHT is swept to WNT, one entry per cycle, before RUN.
module bpu_gshare
    import bpu_gshare_pkg::*;
#(
    parameter int PHT_DEPTH = 1024,
    parameter int GHR_W     = 8,
    parameter int MODE      = 1
) (
    input logic         clk,
    input logic         rst,
    bpu_gshare_if.slave bus
);
    localparam int IDX_W = clog2(PHT_DEPTH);

    bpu_state_t       state, state_next;
    logic [IDX_W-1:0] sweep, idx_f, idx_d, ram_addr;
    logic [GHR_W-1:0] ghr_spec, ghr_ret, ghr_ret_next;
    logic [1:0]       rd_data;
    logic             raw_d, run, ram_we;
    logic             unused;

    assign unused = ^{bus.pcM, bus.pcF[31:IDX_W+2], bus.pcF[1:0], rd_data[0]};

    assign run   = state == BPU_RUN;
    assign idx_f = bus.pcF[IDX_W+1:2] ^ (MODE != 0 ? IDX_W'(ghr_spec) : '0);

    // Truncating the concatenation drops the oldest bit; also valid for GHR_W=1.
    assign ghr_ret_next = GHR_W'({ghr_ret, bus.actual_takeM});

    always_ff @(posedge clk)
        if (rst) begin
            state <= BPU_INIT;
            sweep <= '0;
        end else begin
            state <= state_next;
            if (!run) sweep <= sweep + IDX_W'(1);
        end

    always_comb begin
        state_next = state;
        ram_we     = run ? bus.branchM : 1'b1;
        ram_addr   = run ? bus.pht_idxM : sweep;
        if (!run && sweep == IDX_W'(PHT_DEPTH - 1)) state_next = BPU_RUN;
    end

    pht_ram #(.DEPTH(PHT_DEPTH), .IDX_W(IDX_W)) u_pht (
        .clk   (clk),
        .we    (ram_we),
        .init  (!run),
        .taken (bus.actual_takeM),
        .waddr (ram_addr),
        .raddr (idx_f),
        .rdata (rd_data)
    );

    // D-stage register: stall wins over flush.
    always_ff @(posedge clk)
        if (rst) begin
            idx_d <= '0;
            raw_d <= 1'b0;
        end else if (!bus.stallD) begin
            idx_d <= bus.flushD ? '0 : idx_f;
            raw_d <= bus.flushD ? 1'b0 : rd_data[1];
        end

    // A mispredict rebuilds the speculative history from the retired one.
    always_ff @(posedge clk)
        if (rst) begin
            ghr_spec <= '0;
            ghr_ret  <= '0;
        end else if (run) begin
            if (bus.branchM) ghr_ret <= ghr_ret_next;
            if (bus.mispredM) ghr_spec <= ghr_ret_next;
            else if (bus.branchD && !bus.stallD && !bus.flushD)
                ghr_spec <= GHR_W'({ghr_spec, bus.pred_takeD});
        end

    assign bus.pht_idxD   = idx_d;
    assign bus.pred_takeD = raw_d & bus.branchD & run;
    assign bus.mispredM   = bus.branchM & (bus.pred_takeM ^ bus.actual_takeM);
    assign bus.init_done  = run;
endmodule

// File: tb/tb_bpu_gshare.sv
// tb_bpu_gshare: directed self-checking bench for bpu_gshare.
// dut0: bimodal, 1024 entries. dut1: gshare, 16 entries, 4-bit history.
module tb_bpu_gshare;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   bad;
    logic p;

    always #5 clk = ~clk;

    bpu_gshare_if #(.IDX_W(10)) b0();
    bpu_gshare_if #(.IDX_W(4))  b1();

    bpu_gshare #(.PHT_DEPTH(1024), .GHR_W(8), .MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));
    bpu_gshare #(.PHT_DEPTH(16),   .GHR_W(4), .MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic train0(input logic [9:0] idx, input logic t);
        b0.branchM = 1'b1; b0.actual_takeM = t; b0.pred_takeM = 1'b0; b0.pht_idxM = idx;
        tick;
        b0.branchM = 1'b0;
    endtask

    task automatic look0(input logic [31:0] pc);
        b0.pcF = pc; b0.branchD = 1'b0;
        tick;
        b0.branchD = 1'b1;
        #1;
    endtask

    task automatic resolve1(input logic pred, input logic act);
        b1.branchM = 1'b1; b1.pred_takeM = pred; b1.actual_takeM = act; b1.pht_idxM = '0;
        tick;
        b1.branchM = 1'b0;
    endtask

    initial begin
        {b0.stallD, b0.flushD, b0.pcF, b0.branchD, b0.pcM, b0.branchM, b0.actual_takeM, b0.pred_takeM, b0.pht_idxM} = '0;
        {b1.stallD, b1.flushD, b1.pcF, b1.branchD, b1.pcM, b1.branchM, b1.actual_takeM, b1.pred_takeM, b1.pht_idxM} = '0;
        tick;
        tick;
        check("rst_pred", 32'(b0.pred_takeD), 0);
        check("rst_idx", 32'(b0.pht_idxD), 0);
        check("rst_done", 32'(b0.init_done), 0);
        rst = 1'b0;
        b0.branchD = 1'b1;
        bad = 0;
        for (int i = 0; i < 1023; i++) begin
            b0.pcF = $urandom;
            tick;
            if (b0.pred_takeD !== 1'b0) bad++;
        end
        check("init_done_1023", 32'(b0.init_done), 0);
        check("init_pred_zero", bad, 0);
        tick;
        check("init_done_1024", 32'(b0.init_done), 1);
        b0.branchD = 1'b0;
        bad = 0;
        for (int i = 0; i < 1024; i++) if (dut0.u_pht.mem[i] !== 2'b01) bad++;
        check("sweep_all_wnt", bad, 0);

        b0.branchM = 1'b1; b0.pred_takeM = 1'b1; b0.actual_takeM = 1'b0; #1;
        check("misp_10", 32'(b0.mispredM), 1);
        b0.actual_takeM = 1'b1; #1;
        check("misp_11", 32'(b0.mispredM), 0);
        b0.branchM = 1'b0; b0.actual_takeM = 1'b0; #1;
        check("misp_nobr", 32'(b0.mispredM), 0);

        train0(10'd0, 1'b1);
        check("train_t1", 32'(dut0.u_pht.mem[0]), 32'h2);
        train0(10'd0, 1'b1);
        check("train_t2", 32'(dut0.u_pht.mem[0]), 32'h3);
        look0(32'h1000);
        check("look_pred_t", 32'(b0.pred_takeD), 1);
        check("look_idx0", 32'(b0.pht_idxD), 0);
        train0(10'd5, 1'b1);
        train0(10'd5, 1'b1);
        check("train_e5", 32'(dut0.u_pht.mem[5]), 32'h3);

        look0(32'h1014);
        check("stall_pre_idx", 32'(b0.pht_idxD), 5);
        check("stall_pre_pred", 32'(b0.pred_takeD), 1);
        b0.stallD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b0.pcF = 32'h1008 + 32'(4 * i);
            tick;
            check("stall_idx", 32'(b0.pht_idxD), 5);
            check("stall_pred", 32'(b0.pred_takeD), 1);
        end
        b0.flushD = 1'b1;
        tick;
        check("stallflush_idx", 32'(b0.pht_idxD), 5);
        check("stallflush_pred", 32'(b0.pred_takeD), 1);
        b0.stallD = 1'b0;
        tick;
        check("flush_idx", 32'(b0.pht_idxD), 0);
        check("flush_pred", 32'(b0.pred_takeD), 0);
        b0.flushD = 1'b0; b0.branchD = 1'b0;

        for (int i = 0; i < 4; i++) train0(10'd0, 1'b0);
        check("train_sat0", 32'(dut0.u_pht.mem[0]), 0);
        look0(32'h1000);
        check("look_pred_nt", 32'(b0.pred_takeD), 0);
        b0.branchD = 1'b0;

        // gshare learns a strictly alternating branch
        b1.pcF = 32'h40; b1.pcM = 32'h40;
        for (int k = 0; k < 28; k++) begin
            b1.branchD = 1'b0;
            tick;
            b1.branchD = 1'b1;
            #1;
            p = b1.pred_takeD;
            if (k >= 8) check("gshare_alt", 32'(p), 32'((k % 2) == 0));
            b1.branchM = 1'b1; b1.pred_takeM = p; b1.actual_takeM = ((k % 2) == 0); b1.pht_idxM = b1.pht_idxD;
            tick;
            b1.branchM = 1'b0;
        end
        b1.branchD = 1'b0;

        // build ghr_spec=1011 via a mispredict, then ghr_ret=0101
        resolve1(1'b1, 1'b1);
        resolve1(1'b0, 1'b0);
        resolve1(1'b1, 1'b1);
        resolve1(1'b0, 1'b1);
        resolve1(1'b0, 1'b0);
        resolve1(1'b1, 1'b1);
        resolve1(1'b0, 1'b0);
        resolve1(1'b1, 1'b1);
        check("setup_ret", 32'(dut1.ghr_ret), 32'h5);
        check("setup_spec", 32'(dut1.ghr_spec), 32'hb);
        b1.branchD = 1'b1; b1.branchM = 1'b1; b1.pred_takeM = 1'b1; b1.actual_takeM = 1'b0;
        #1;
        check("repair_misp", 32'(b1.mispredM), 1);
        tick;
        check("repair_ret", 32'(dut1.ghr_ret), 32'ha);
        check("repair_spec", 32'(dut1.ghr_spec), 32'ha);
        b1.branchD = 1'b0; b1.branchM = 1'b0;

        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rerst_done", 32'(b0.init_done), 0);
        check("rerst_sweep", 32'(dut0.sweep), 0);
        repeat (1024) tick;
        check("rerst_done_back", 32'(b0.init_done), 1);
        check("rerst_e5", 32'(dut0.u_pht.mem[5]), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bpu_gshare.md
# bpu_gshare

Parametrised branch prediction unit for the five-stage MIPS pipeline. It is the successor to the fixed bimodal predictor and supports two modes: bimodal, or gshare with a speculative global history register (GHR). It looks up the predictor in F, presents a registered prediction in D, and trains in M from the resolved outcome. On a misprediction it repairs the speculative GHR. After reset it runs a self-initialising sweep of the pattern history table (PHT).

## Interface
- `PHT_DEPTH`, 1024: number of 2-bit counters; power of two, ≥ 16. `IDX_W = log2(PHT_DEPTH)`.
- `GHR_W`, 8: global history length; 1 ≤ `GHR_W` ≤ `IDX_W`.
- `MODE`, 1: 0 = bimodal (index from PC only), 1 = gshare (PC XOR GHR).
- `clk` in 1: clock; single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `stallD` in 1: hold the D-stage prediction register.
- `flushD` in 1: clear the D-stage prediction register.
- `pcF` in 32: fetch PC.
- `branchD` in 1: instruction in D is a conditional branch (from maindec).
- `pcM` in 32: PC of the instruction in M. Unused by the update path, which uses `pht_idxM`; kept for debug.
- `branchM` in 1: instruction in M is a conditional branch.
- `actual_takeM` in 1: resolved direction.
- `pred_takeM` in 1: prediction carried down the pipeline for this branch.
- `pht_idxM` in `IDX_W`: lookup index carried down the pipeline for this branch.
- `pred_takeD` out 1: predicted taken, qualified by `branchD`.
- `pht_idxD` out `IDX_W`: index used for the D-stage prediction. The pipeline carries it to M.
- `mispredM` out 1: combinational `branchM & (pred_takeM ^ actual_takeM)`; drives `flush_pred_failedM`.
- `init_done` out 1: high once the PHT sweep completes.

## Operation
- FSM has two states, INIT and RUN.
  - Reset enters INIT with the sweep counter at 0.
  - INIT writes 2'b01 (weakly not-taken) to entry `sweep`, one entry per cycle.
  - After writing entry `PHT_DEPTH-1`, the FSM moves to RUN and sets `init_done`.
- During INIT:
  - `pred_takeD` = 0.
  - PHT updates are ignored.
  - GHR updates are ignored.
  - `mispredM` still evaluates normally.
- Lookup index (F stage):
  - MODE 0: `idxF = pcF[IDX_W+1:2]`.
  - MODE 1: `idxF = pcF[IDX_W+1:2] ^ {{(IDX_W-GHR_W){1'b0}}, ghr_spec}`.
- D register behaviour:
  - When `~stallD`, it captures `idxF` into `pht_idxD` and `PHT[idxF][1]` into the raw prediction.
  - `flushD` (without stall) clears both to 0.
  - `stallD` holds; `stallD` takes priority over `flushD`.
- `pred_takeD = raw & branchD & init_done`.
- Counter update (M stage, RUN only, when `branchM`):
  - Entry updated: `PHT[pht_idxM]`.
  - Taken: saturating increment, capped at 3.
  - Not taken: saturating decrement, floored at 0.
- Retired GHR: when `branchM` in RUN, `ghr_ret <= {ghr_ret[GHR_W-2:0], actual_takeM}`.
- Speculative GHR:
  - When `branchD & ~stallD & ~flushD` in RUN, `ghr_spec <= {ghr_spec[GHR_W-2:0], pred_takeD}`.
  - On `mispredM`, `ghr_spec` is instead loaded with the new `ghr_ret` value, i.e. `ghr_ret` shifted by `actual_takeM`.
  - Mispredict takes priority over the D shift.
- In MODE 0 both GHRs are still maintained but never used for indexing.
- Reset clears `ghr_spec`, `ghr_ret`, the D register, `sweep` and `init_done`.

## Timing
- Lookup latency: `pcF` at cycle n gives `pred_takeD` valid at cycle n+1.
- Update: the PHT write is visible to lookups from cycle n+1.
- Same-cycle read/write to the same index: the read returns the pre-update value. There is no bypass.
- Init takes exactly `PHT_DEPTH` cycles after reset deasserts. `init_done` rises on cycle `PHT_DEPTH`.
- `rst` asserted mid-INIT or mid-RUN restarts the sweep from 0 on the next edge.
- `mispredM` has zero latency from its inputs and is combinational only.
- All outputs other than `mispredM` reset to 0.

## Structure
- The shared pipeline package holds:
  - counter encodings `SNT=2'b00`, `WNT=2'b01`, `WT=2'b10`, `ST=2'b11`;
  - the FSM state enum `{BPU_INIT, BPU_RUN}`;
  - the `clog2` helper used to derive `IDX_W`.
- Sub-module `pht_ram`: `PHT_DEPTH`×2 array with one asynchronous read port and one write port.
  - The write port is muxed between the sweep and the M-stage update.
  - It maps to distributed RAM.
- GHR logic, the FSM and the D register sit in the top level.

## Test plan
- Reset, then idle: `init_done` is 0 for 1024 cycles and 1 on cycle 1024. Read back every entry as 01. `pred_takeD` = 0 throughout.
- Training, MODE 0: the same branch at pc 0x1000 resolves taken twice. The entry goes 01→10→11 and the next lookup gives `pred_takeD`=1. Four not-taken resolutions saturate the entry at 00.
- Gshare learning, MODE 1, `GHR_W`=4: a single branch alternates T/N. After warm-up, predictions match outcomes for 20 consecutive branches.
- Mispredict repair:
  - Setup: `ghr_ret`=4'b0101, `ghr_spec`=4'b1011, and a branch in M with `pred_takeM`=1, `actual_takeM`=0, while `branchD` is also active.
  - Expected: `mispredM`=1 and, next cycle, `ghr_ret`=`ghr_spec`=4'b1010.
- Stall/flush:
  - `stallD`=1 for 3 cycles holds `pred_takeD` and `pht_idxD` stable while `pcF` changes.
  - `flushD` clears them to 0.
  - `stallD`+`flushD` together hold.
- Reset mid-RUN: after training entry 5 to 11, assert `rst` for 1 cycle. The sweep restarts, `init_done` drops, and entry 5 reads 01 after the sweep.
